// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - combinational next-PC selection for the fetch stage
//
// Ports:
//   pc_i, imm_i, rs1_i      current PC, sign-extended immediate, JALR base
//   jal_i, jalr_i, branch_i decode from the controller
//   taken_i                 branch comparator result (only meaningful with branch_i)
//   target_o                selected next PC, modulo 2^XLEN
//   misaligned_o            selected control-transfer target has bit[1] set
module next_pc_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic            branch_i,
    input  logic            taken_i,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        jalr_sum     = rs1_i + imm_i;
        target_o     = pc_i + XLEN'(4);
        // pc is always word aligned, so the sequential path never misaligns
        misaligned_o = 1'b0;
        if (jalr_i) begin
            target_o     = {jalr_sum[XLEN-1:1], 1'b0};
            misaligned_o = jalr_sum[1];
        end else if (jal_i || (branch_i && taken_i)) begin
            target_o     = pc_i + imm_i;
            misaligned_o = target_o[1];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, imem handshake, instruction hold
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   imem_req_o/addr_o/gnt_i            request phase of the instruction memory
//   imem_rvalid_i/rdata_i              response phase of the instruction memory
//   instr_o, pc_o, pc_plus4_o          held instruction, its PC and link value
//   instr_valid_o, instr_ready_i       hold/retire handshake with the core
//   jal_i, jalr_i, branch_i            controller decode for the held instruction
//   branch_taken_i, imm_i, rs1_i       execute results used to form the next PC
//   misaligned_o                       one-cycle pulse after a trapped redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_PC_DEF)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic            branch_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            misaligned_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] target;
    logic            target_misaligned;

    next_pc_gen #(
        .XLEN (XLEN)
    ) u_next_pc_gen (
        .pc_i         (pc_q),
        .imm_i        (imm_i),
        .rs1_i        (rs1_i),
        .jal_i        (jal_i),
        .jalr_i       (jalr_i),
        .branch_i     (branch_i),
        .taken_i      (branch_taken_i),
        .target_o     (target),
        .misaligned_o (target_misaligned)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = 1'b0;
        unique case (state_q)
            FETCH: begin
                // rvalid without gnt belongs to a request from before reset: drop it
                if (imem_gnt_i) begin
                    if (imem_rvalid_i) begin
                        instr_d = imem_rdata_i;
                        state_d = VALID;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    state_d = VALID;
                end
            end
            VALID: begin
                // redirect inputs only matter in the retire cycle
                if (instr_ready_i) begin
                    state_d = FETCH;
                    if (target_misaligned) begin
                        pc_d         = TRAP_PC;
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // req is gated by reset so it is low while rst_ni is held, not just after
    assign imem_req_o    = rst_ni && (state_q == FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + XLEN'(4);
    assign instr_valid_o = (state_q == VALID);
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        jal_i;
    logic        jalr_i;
    logic        branch_i;
    logic        branch_taken_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_i;
    logic        misaligned_o;

    fetch_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .jal_i          (jal_i),
        .jalr_i         (jalr_i),
        .branch_i       (branch_i),
        .branch_taken_i (branch_taken_i),
        .imm_i          (imm_i),
        .rs1_i          (rs1_i),
        .misaligned_o   (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mis_cyc = -1;
    int          hs_cyc  = 0;
    bit          chk_en  = 1'b0;
    logic [31:0] exp_pc    = RESET_PC;
    logic [31:0] exp_instr = NOP;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Architectural next-PC rule: {misaligned, next pc}
    function automatic logic [32:0] model_next(input logic [31:0] pc, input logic jal,
                                               input logic jalr, input logic br, input logic tk,
                                               input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] t;
        if (jalr) begin
            t = (rs1 + imm) & 32'hFFFF_FFFE;
            return {t[1], t};
        end
        if (jal || (br && tk)) begin
            t = pc + imm;
            return {t[1], t};
        end
        return {1'b0, pc + 32'd4};
    endfunction

    // Per-cycle comparison of the DUT against the model state
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && chk_en) begin
                if (imem_req_o)
                    chk("imem_addr", imem_addr_o, exp_pc);
                if (instr_valid_o) begin
                    chk("pc_o", pc_o, exp_pc);
                    chk("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
                    chk("instr_o", instr_o, exp_instr);
                end
                chk("misaligned", {31'd0, misaligned_o}, {31'd0, cyc == mis_cyc});
            end
            cyc++;
        end
    end

    // One instruction: request, grant/response with delays, hold, retire with redirect
    task automatic do_instr(input logic [31:0] data, input int gnt_dly, input int rv_dly,
                            input int rdy_dly, input bit stray,
                            input logic jal, input logic jalr, input logic br, input logic tk,
                            input logic [31:0] imm, input logic [31:0] rs1);
        int n;
        logic [32:0] m;
        n = 0;
        @(negedge clk_i);
        while (!imem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("req_seen", {31'd0, imem_req_o}, 32'd1);
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk_i);
            chk("req_hold", {31'd0, imem_req_o}, 32'd1);
        end
        imem_gnt_i = 1'b1;
        if (rv_dly == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = data;
            exp_instr     = data;
        end
        @(posedge clk_i);
        #1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hBAD0_BAD0;
        for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk_i);
            chk("wait_req_low", {31'd0, imem_req_o}, 32'd0);
            chk("wait_not_valid", {31'd0, instr_valid_o}, 32'd0);
            if (i == rv_dly - 1) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = data;
                exp_instr     = data;
                @(posedge clk_i);
                #1;
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'hBAD0_BAD0;
            end
        end
        @(negedge clk_i);
        chk("valid_up", {31'd0, instr_valid_o}, 32'd1);
        for (int i = 0; i < rdy_dly; i++) begin
            if (stray) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'hFFFF_0000 | 32'(i);
                jal_i         = 1'b1;
                imm_i         = 32'h0000_0080;
            end
            @(posedge clk_i);
            #1;
            imem_rvalid_i = 1'b0;
            jal_i         = 1'b0;
            imm_i         = 32'd0;
            @(negedge clk_i);
            chk("hold_no_req", {31'd0, imem_req_o}, 32'd0);
            chk("hold_valid", {31'd0, instr_valid_o}, 32'd1);
        end
        instr_ready_i  = 1'b1;
        jal_i          = jal;
        jalr_i         = jalr;
        branch_i       = br;
        branch_taken_i = tk;
        imm_i          = imm;
        rs1_i          = rs1;
        @(posedge clk_i);
        m = model_next(exp_pc, jal, jalr, br, tk, imm, rs1);
        #1;
        hs_cyc = cyc;
        if (m[32]) begin
            exp_pc  = TRAP_PC;
            mis_cyc = cyc;
        end else begin
            exp_pc = m[31:0];
        end
        instr_ready_i  = 1'b0;
        jal_i          = 1'b0;
        jalr_i         = 1'b0;
        branch_i       = 1'b0;
        branch_taken_i = 1'b0;
        imm_i          = 32'd0;
        rs1_i          = 32'd0;
    endtask

    task automatic plain(input logic [31:0] data);
        do_instr(data, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int last;
        rst_ni         = 1'b0;
        imem_gnt_i     = 1'b0;
        imem_rvalid_i  = 1'b0;
        imem_rdata_i   = 32'd0;
        instr_ready_i  = 1'b0;
        jal_i          = 1'b0;
        jalr_i         = 1'b0;
        branch_i       = 1'b0;
        branch_taken_i = 1'b0;
        imm_i          = 32'd0;
        rs1_i          = 32'd0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_instr", instr_o, NOP);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Zero-wait sequential fetch: 2 cycles per instruction
        plain(32'h0010_0093);
        last = hs_cyc;
        plain(32'h0020_0113);
        chk("latency_2", 32'(hs_cyc - last), 32'd2);
        last = hs_cyc;
        plain(32'h0030_0193);
        chk("latency_3", 32'(hs_cyc - last), 32'd2);
        chk("model_seq", exp_pc, 32'h0000_000C);

        // Delayed grant and response
        do_instr(32'h1111_1111, 3, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("model_delay", exp_pc, 32'h0000_0010);

        // Core stalls 5 cycles; stray rvalid and redirect inputs ignored
        do_instr(32'h2222_2222, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("model_stall", exp_pc, 32'h0000_0014);

        // Control transfers
        do_instr(32'h3333_3333, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_002C, 32'd0);
        chk("model_to40", exp_pc, 32'h0000_0040);
        do_instr(32'h4444_4444, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
        chk("model_jal_back", exp_pc, 32'h0000_0030);
        do_instr(32'h5555_5555, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd0);
        do_instr(32'h6666_6666, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        chk("model_br_nt", exp_pc, 32'h0000_0044);
        do_instr(32'h7777_7777, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0);
        do_instr(32'h8888_8888, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0101);
        chk("model_jalr", exp_pc, 32'h0000_0104);
        do_instr(32'h9999_9999, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'd0);
        chk("model_prio", exp_pc, 32'h0000_0008);
        do_instr(32'hAAAA_AAAA, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0);
        chk("model_br_t", exp_pc, 32'h0000_0000);
        do_instr(32'hBBBB_BBBB, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'd0);
        chk("model_tk_nobr", exp_pc, 32'h0000_0004);
        do_instr(32'hCCCC_CCCC, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0);

        // Misaligned JAL target traps
        do_instr(32'hDDDD_DDDD, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0006, 32'd0);
        chk("model_trap", exp_pc, 32'h0000_0100);
        plain(32'hEEEE_EEEE);
        chk("model_after_trap", exp_pc, 32'h0000_0104);

        // Reset while waiting for a response
        @(negedge clk_i);
        chk("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
        imem_gnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        imem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("in_wait", {31'd0, imem_req_o}, 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req_o}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("arst_pc", pc_o, RESET_PC);
        chk("arst_instr", instr_o, NOP);
        exp_pc    = RESET_PC;
        exp_instr = NOP;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(negedge clk_i);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        @(posedge clk_i);
        #1;
        imem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("late_rvalid_drop", {31'd0, instr_valid_o}, 32'd0);
        chk("late_rvalid_req", {31'd0, imem_req_o}, 32'd1);
        chk("late_rvalid_addr", imem_addr_o, RESET_PC);
        plain(32'h0040_0213);
        chk("model_post_rst", exp_pc, 32'h0000_0004);

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
